// File: rtl/p4_pkg.sv
// p4_pkg: opcodes, instruction field positions and pipeline-register types for pipeline_core_p4
package p4_pkg;
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_LOAD  = 4'h4;
  localparam logic [3:0] OP_STORE = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_BEQ   = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'hF;
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 3;
  localparam int IMM_LSB = 0;
  typedef struct packed {
    logic       valid;
    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] imm;
  } dec_t;
  typedef struct packed {
    logic       valid;
    logic       we;
    logic       retire;
    logic [2:0] rd;
  } wb_t;
  function automatic dec_t decode(input logic v, input logic [15:0] i);
    return '{valid: v, op: i[OP_LSB+:4], rd: i[RD_LSB+:3], rs1: i[RS1_LSB+:3],
             rs2: i[RS2_LSB+:3], imm: i[IMM_LSB+:3]};
  endfunction
  function automatic logic is_legal(input logic [3:0] op);
    return op inside {OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LOAD, OP_STORE, OP_BEQ, OP_HALT};
  endfunction
  function automatic logic writes_rd(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LOAD};
  endfunction
endpackage

// File: rtl/p4_alu.sv
// p4_alu: combinational ALU; unlisted ops (ADD, LOAD/STORE address) add
module p4_alu
  import p4_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              eq
);
  always_comb begin
    y  = op == OP_SUB ? a - b :
         op == OP_AND ? a & b :
         op == OP_OR  ? a | b :
         op == OP_XOR ? a ^ b : a + b;
    eq = a == b;
  end
endmodule

// File: rtl/pipeline_core_p4.sv
// pipeline_core_p4: four-stage IF/ID/EX/WB core with forwarding, branch flush, halt and preset ports
module pipeline_core_p4
  import p4_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 32,
  localparam int IA_W      = $clog2(IMEM_DEPTH),
  localparam int DA_W      = $clog2(DMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              prog_we,
  input  logic [IA_W-1:0]   prog_addr,
  input  logic [15:0]       prog_wdata,
  input  logic              rf_we,
  input  logic [2:0]        rf_addr,
  input  logic [DATA_W-1:0] rf_wdata,
  input  logic              dm_we,
  input  logic [DA_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [2:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [IA_W-1:0]   pc,
  output logic              halted,
  output logic              illegal,
  output logic [15:0]       retired_cnt
);
  logic [15:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];
  logic [DATA_W-1:0] rf [8];
  logic              if_v;
  logic [15:0]       if_ins;
  logic [IA_W-1:0]   if_pc;
  dec_t              d, ie;
  logic [DATA_W-1:0] ie_a, ie_b;
  logic [IA_W-1:0]   ie_pc;
  wb_t               ew, nx;
  logic [DATA_W-1:0] ew_d;
  logic              adv, taken, halt_ex, ill_ex, eq, is_mem;
  logic [DATA_W-1:0] id_a, id_b, fa, fb, alu_y, ex_d;
  logic [DA_W-1:0]   dm_a;
  logic [IA_W-1:0]   br_tgt;
  assign adv       = run & ~halted;
  assign dbg_rdata = rf[dbg_raddr];
  p4_alu #(.DATA_W(DATA_W)) u_alu (
    .op(ie.op),
    .a (fa),
    .b (is_mem ? DATA_W'(ie.imm) : fb),
    .y (alu_y),
    .eq(eq)
  );
  // ID reads write-first from WB; EX forwards from EX_WB, so no dependency ever stalls
  always_comb begin
    d       = decode(if_v, if_ins);
    id_a    = (ew.valid && ew.we && ew.rd == d.rs1) ? ew_d : rf[d.rs1];
    id_b    = (ew.valid && ew.we && ew.rd == d.rs2) ? ew_d : rf[d.rs2];
    fa      = (ew.valid && ew.we && ew.rd == ie.rs1) ? ew_d : ie_a;
    fb      = (ew.valid && ew.we && ew.rd == ie.rs2) ? ew_d : ie_b;
    is_mem  = ie.op == OP_LOAD || ie.op == OP_STORE;
    dm_a    = DA_W'(alu_y);
    ex_d    = ie.op == OP_LOAD ? dmem[dm_a] : alu_y;
    taken   = ie.valid && ie.op == OP_BEQ && eq;
    halt_ex = ie.valid && ie.op == OP_HALT;
    ill_ex  = ie.valid && !is_legal(ie.op);
    br_tgt  = ie_pc + IA_W'($signed(ie.imm));
    nx      = '{valid: ie.valid & ~halt_ex, we: ie.valid & writes_rd(ie.op),
                retire: ie.valid & is_legal(ie.op) & (ie.op != OP_HALT), rd: ie.rd};
  end
  always_ff @(posedge clk) begin
    if (!run && prog_we) imem[prog_addr] <= prog_wdata;
  end
  always_ff @(posedge clk) begin
    if (!run && dm_we) dmem[dm_addr] <= dm_wdata;
    else if (adv && ie.valid && ie.op == OP_STORE) dmem[dm_a] <= fb;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= '0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      retired_cnt <= '0;
      if_v        <= 1'b0;
      if_ins      <= '0;
      if_pc       <= '0;
      ie          <= '0;
      ie_a        <= '0;
      ie_b        <= '0;
      ie_pc       <= '0;
      ew          <= '0;
      ew_d        <= '0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (adv) begin
      pc          <= halt_ex ? pc : taken ? br_tgt : pc + IA_W'(1);
      if_v        <= !(taken || halt_ex);
      if_ins      <= imem[pc];
      if_pc       <= pc;
      ie          <= (taken || halt_ex) ? '0 : d;
      ie_a        <= id_a;
      ie_b        <= id_b;
      ie_pc       <= if_pc;
      ew          <= nx;
      ew_d        <= ex_d;
      halted      <= halted | halt_ex;
      illegal     <= illegal | ill_ex;
      retired_cnt <= retired_cnt + 16'(ew.valid & ew.retire);
      if (ew.valid && ew.we) rf[ew.rd] <= ew_d;
    end else if (!run && rf_we) begin
      rf[rf_addr] <= rf_wdata;
    end
  end
endmodule

// File: tb/tb_pipeline_core_p4.sv
// tb_pipeline_core_p4: directed and random programs checked against an instruction-level model
module tb_pipeline_core_p4;
  logic        clk = 0, reset = 1, run = 0, prog_we = 0, rf_we = 0, dm_we = 0;
  logic [3:0]  prog_addr = '0;
  logic [15:0] prog_wdata = '0;
  logic [2:0]  rf_addr = '0, dbg_raddr = '0;
  logic [7:0]  rf_wdata = '0, dm_wdata = '0, dbg_rdata;
  logic [4:0]  dm_addr = '0;
  logic [3:0]  pc;
  logic        halted, illegal;
  logic [15:0] retired_cnt;
  int          n_assert = 0, n_fail = 0;
  logic [15:0] prog [16];
  logic [7:0]  init_reg [8], init_dm [32], mreg [8], mdm [32];
  int          m_ret;
  logic        m_ill;
  int          ops [11] = '{0, 1, 2, 3, 6, 7, 4, 5, 8, 8, 11};
  pipeline_core_p4 dut (
    .clk(clk), .reset(reset), .run(run),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .pc(pc),
    .halted(halted), .illegal(illegal), .retired_cnt(retired_cnt)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic rd_reg(input int r, output logic [7:0] v);
    dbg_raddr = 3'(r);
    #1;
    v = dbg_rdata;
  endtask
  function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int rs2, input int imm);
    return {op[3:0], rd[2:0], rs1[2:0], rs2[2:0], imm[2:0]};
  endfunction
  task automatic set_base();
    for (int i = 0; i < 16; i++) prog[i] = 16'h0000;
    for (int i = 0; i < 8; i++) init_reg[i] = 8'h00;
    for (int i = 0; i < 32; i++) init_dm[i] = 8'($urandom);
    init_reg[2] = 10; init_reg[3] = 20; init_reg[5] = 50; init_reg[6] = 15;
    init_dm[25] = 8'hA5;
  endtask
  task automatic do_reset();
    run = 0;
    reset = 0;
    tick();
    reset = 1;
    tick();
  endtask
  // all three preset ports written in the same cycles
  task automatic preset(input bit rf_only);
    for (int i = 0; i < 32; i++) begin
      rf_we = i < 8;               rf_addr = 3'(i);   rf_wdata = init_reg[i % 8];
      prog_we = !rf_only && i < 16; prog_addr = 4'(i); prog_wdata = prog[i % 16];
      dm_we = !rf_only;            dm_addr = 5'(i);   dm_wdata = init_dm[i];
      tick();
    end
    rf_we = 0; prog_we = 0; dm_we = 0;
  endtask
  // sequential instruction-set interpreter: one instruction at a time, no pipeline
  function automatic void model();
    logic [3:0] p = 0, nx, op;
    logic [2:0] rd, s1, s2, im3;
    logic [7:0] a, b;
    int         im, st = 0;
    logic       done = 0;
    mreg = init_reg; mdm = init_dm; m_ret = 0; m_ill = 0;
    while (!done && st < 1000) begin
      op = prog[p][15:12]; rd = prog[p][11:9]; s1 = prog[p][8:6]; s2 = prog[p][5:3]; im3 = prog[p][2:0];
      im = int'(im3);
      a = mreg[s1]; b = mreg[s2]; nx = p + 4'd1; st++;
      case (op)
        4'd0: ;
        4'd1: mreg[rd] = a + b;
        4'd2: mreg[rd] = a - b;
        4'd3: mreg[rd] = a & b;
        4'd6: mreg[rd] = a | b;
        4'd7: mreg[rd] = a ^ b;
        4'd4: mreg[rd] = mdm[5'(int'(a) + im)];
        4'd5: mdm[5'(int'(a) + im)] = b;
        4'd8: if (a == b) nx = p + 4'(im > 3 ? im - 8 : im);
        4'd15: done = 1;
        default: m_ill = 1;
      endcase
      if (op <= 4'd8) m_ret++;
      p = nx;
    end
  endfunction
  task automatic run_to_halt(input string tag);
    int c = 0;
    run = 1;
    while (!halted && c < 100) begin
      tick();
      c++;
    end
    chk({tag, "_halted"}, 32'(halted), 1);
    run = 0;
  endtask
  task automatic check_state(input string tag);
    logic [7:0] v;
    for (int r = 0; r < 8; r++) begin
      rd_reg(r, v);
      chk($sformatf("%s_R%0d", tag, r), 32'(v), 32'(mreg[r]));
    end
    chk({tag, "_retired"}, 32'(retired_cnt), 32'(m_ret));
    chk({tag, "_illegal"}, 32'(illegal), 32'(m_ill));
  endtask
  task automatic scenario(input string tag);
    do_reset();
    preset(0);
    model();
    run_to_halt(tag);
    check_state(tag);
  endtask
  initial begin
    logic [7:0] v;
    #2 reset = 0;
    tick();
    tick();
    chk("rst_pc", 32'(pc), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_retired", 32'(retired_cnt), 0);
    for (int r = 0; r < 8; r++) begin
      rd_reg(r, v);
      chk($sformatf("rst_R%0d", r), 32'(v), 0);
    end
    reset = 1;
    set_base();
    prog[0] = enc(1, 1, 2, 3, 0);
    prog[1] = enc(2, 4, 5, 6, 0);
    prog[2] = enc(3, 7, 1, 4, 0);
    prog[3] = enc(4, 2, 3, 0, 5);
    prog[4] = enc(15, 0, 0, 0, 0);
    do_reset();
    preset(0);
    model();
    run = 1;
    repeat (3) tick();
    rd_reg(1, v);
    chk("lat_R1_edge3", 32'(v), 0);
    tick();
    rd_reg(1, v);
    chk("lat_R1_edge4", 32'(v), 30);
    run_to_halt("main");
    check_state("main");
    rd_reg(4, v); chk("main_R4_const", 32'(v), 35);
    rd_reg(7, v); chk("main_R7_const", 32'(v), 2);
    rd_reg(2, v); chk("main_R2_const", 32'(v), 32'hA5);
    chk("main_ret_const", 32'(retired_cnt), 4);
    do_reset();
    preset(0);
    run = 1;
    repeat (3) tick();
    run = 0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("frz_pc_%0d", k), 32'(pc), 3);
      rd_reg(1, v);
      chk($sformatf("frz_R1_%0d", k), 32'(v), 0);
      tick();
    end
    run_to_halt("frz");
    check_state("frz");
    do_reset();
    preset(0);
    run = 1;
    repeat (5) tick();
    chk("mid_retired", 32'(retired_cnt), 2);
    rd_reg(1, v);
    chk("mid_R1", 32'(v), 30);
    reset = 0;
    #1;
    chk("mid_rst_pc", 32'(pc), 0);
    chk("mid_rst_halted", 32'(halted), 0);
    chk("mid_rst_retired", 32'(retired_cnt), 0);
    for (int r = 0; r < 8; r++) begin
      rd_reg(r, v);
      chk($sformatf("mid_rst_R%0d", r), 32'(v), 0);
    end
    tick();
    run = 0;
    reset = 1;
    tick();
    preset(1);
    run_to_halt("rerun");
    check_state("rerun");
    set_base();
    prog[0] = enc(1, 1, 2, 3, 0);
    prog[1] = enc(8, 0, 1, 1, 2);
    prog[2] = enc(1, 5, 2, 2, 0);
    prog[3] = enc(15, 0, 0, 0, 0);
    scenario("br");
    rd_reg(5, v); chk("br_R5_const", 32'(v), 50);
    chk("br_ret_const", 32'(retired_cnt), 2);
    set_base();
    prog[0] = enc(5, 0, 3, 5, 1);
    prog[1] = enc(4, 6, 3, 0, 1);
    prog[2] = enc(15, 0, 0, 0, 0);
    scenario("stld");
    rd_reg(6, v); chk("stld_R6_const", 32'(v), 50);
    set_base();
    prog[0] = 16'hA000;
    prog[1] = enc(1, 1, 2, 3, 0);
    prog[2] = enc(15, 0, 0, 0, 0);
    scenario("ill");
    repeat (3) tick();
    chk("ill_sticky", 32'(illegal), 1);
    chk("ill_ret_const", 32'(retired_cnt), 1);
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 8; i++) init_reg[i] = 8'($urandom);
      for (int i = 0; i < 32; i++) init_dm[i] = 8'($urandom);
      for (int i = 0; i < 13; i++) begin
        int op;
        op = ops[$urandom_range(0, 10)];
        prog[i] = enc(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      op == 8 ? $urandom_range(1, 3) : $urandom_range(0, 7));
      end
      for (int i = 13; i < 16; i++) prog[i] = enc(15, 0, 0, 0, 0);
      scenario($sformatf("rnd%0d", t));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
